// File: rtl/multi_edge_detector.sv
// N-channel edge detector: synchroniser, per-channel edge mode, stretched pulses, sticky status.
// Optional per-channel debounce filter is built when DEBOUNCE_EN is defined.
module multi_edge_detector #(
  parameter int NCH          = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int PULSE_LEN    = 1,
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   levelin,
  input  logic [2*NCH-1:0] mode,
  input  logic [NCH-1:0]   sticky_clr,
  output logic [NCH-1:0]   outpulse,
  output logic [NCH-1:0]   edge_sticky,
  output logic             any_pulse
);

  localparam int CW = $clog2(PULSE_LEN + 1);

  // Low for exactly one cycle after reset so history loads without reporting an edge.
  logic primed_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      primed_q <= 1'b0;
    end else begin
      primed_q <= 1'b1;
    end
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic          lvl_s;
    logic          lvl_f;
    logic          prev_q;
    logic          hit;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          pulse_q;
    logic          sticky_q;

    if (SYNC_STAGES == 0) begin : g_nosync
      assign lvl_s = levelin[gi];
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= levelin[gi];
          for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_q[k] <= sync_q[k-1];
          end
        end
      end

      assign lvl_s = sync_q[SYNC_STAGES-1];
    end

`ifdef DEBOUNCE_EN
    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    logic          f_q;
    logic [DW-1:0] db_cnt_q;

    // Accept a new level only after it differed from the filtered one for DEBOUNCE_CYC cycles.
    always_ff @(posedge clk) begin
      if (rst) begin
        f_q      <= 1'b0;
        db_cnt_q <= '0;
      end else if (!primed_q) begin
        f_q      <= lvl_s;
        db_cnt_q <= '0;
      end else if (lvl_s == f_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q == DW'(DEBOUNCE_CYC - 1)) begin
        f_q      <= lvl_s;
        db_cnt_q <= '0;
      end else begin
        db_cnt_q <= db_cnt_q + DW'(1);
      end
    end

    assign lvl_f = f_q;
`else
    assign lvl_f = lvl_s;
`endif

    assign hit = primed_q & ((mode[2*gi]   &  lvl_f & ~prev_q) |
                             (mode[2*gi+1] & ~lvl_f &  prev_q));

    always_comb begin
      cnt_d = cnt_q;
      if (hit) begin
        cnt_d = CW'(PULSE_LEN);
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - CW'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        prev_q   <= 1'b0;
        cnt_q    <= '0;
        pulse_q  <= 1'b0;
        sticky_q <= 1'b0;
      end else begin
        // While priming the filter still holds its reset value, so take history from s.
        prev_q   <= primed_q ? lvl_f : lvl_s;
        cnt_q    <= cnt_d;
        pulse_q  <= (cnt_d != '0);
        sticky_q <= hit | (sticky_q & ~sticky_clr[gi]);
      end
    end

    assign outpulse[gi]    = pulse_q;
    assign edge_sticky[gi] = sticky_q;
  end

  assign any_pulse = |outpulse;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Directed checks of multi_edge_detector across several parameter sets.
module tb_multi_edge_detector;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // A: 4 channels, no synchroniser, 1-cycle pulse
  logic [3:0] a_lvl = '0, a_clr = '0, a_out, a_stk;
  logic [7:0] a_mode = '0;
  logic       a_any;
  // B: 1 channel, 2-stage synchroniser, 1-cycle pulse
  logic b_lvl = 1'b0, b_clr = 1'b0, b_out, b_stk, b_any;
  logic [1:0] b_mode = 2'b11;
  // C: 1 channel, no synchroniser, 5-cycle pulse
  logic c_lvl = 1'b0, c_clr = 1'b0, c_out, c_stk, c_any;
  logic [1:0] c_mode = 2'b01;
  // D: 1 channel, no synchroniser, debounce of 4 when enabled
  logic d_lvl = 1'b0, d_clr = 1'b0, d_out, d_stk, d_any;
  logic [1:0] d_mode = 2'b01;

  int n_cmp = 0;
  int n_bad = 0;

  multi_edge_detector #(.NCH(4), .SYNC_STAGES(0), .PULSE_LEN(1), .DEBOUNCE_CYC(4)) dut_a (
    .clk(clk), .rst(rst), .levelin(a_lvl), .mode(a_mode), .sticky_clr(a_clr),
    .outpulse(a_out), .edge_sticky(a_stk), .any_pulse(a_any));
  multi_edge_detector #(.NCH(1), .SYNC_STAGES(2), .PULSE_LEN(1), .DEBOUNCE_CYC(4)) dut_b (
    .clk(clk), .rst(rst), .levelin(b_lvl), .mode(b_mode), .sticky_clr(b_clr),
    .outpulse(b_out), .edge_sticky(b_stk), .any_pulse(b_any));
  multi_edge_detector #(.NCH(1), .SYNC_STAGES(0), .PULSE_LEN(5), .DEBOUNCE_CYC(4)) dut_c (
    .clk(clk), .rst(rst), .levelin(c_lvl), .mode(c_mode), .sticky_clr(c_clr),
    .outpulse(c_out), .edge_sticky(c_stk), .any_pulse(c_any));
  multi_edge_detector #(.NCH(1), .SYNC_STAGES(0), .PULSE_LEN(1), .DEBOUNCE_CYC(4)) dut_d (
    .clk(clk), .rst(rst), .levelin(d_lvl), .mode(d_mode), .sticky_clr(d_clr),
    .outpulse(d_out), .edge_sticky(d_stk), .any_pulse(d_any));

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with channel 2 of A held high to cover the no-spurious-edge case
    rst    = 1'b1;
    a_mode = 8'h55;
    a_lvl  = 4'b0100;
    tick(); tick(); tick();
    check_val("rst_a_out", {28'd0, a_out}, 32'h0);
    check_val("rst_a_stk", {28'd0, a_stk}, 32'h0);
    check_val("rst_a_any", {31'd0, a_any}, 32'h0);
    check_val("rst_bcd_out", {29'd0, b_out, c_out, d_out}, 32'h0);
    check_val("rst_d_stk", {31'd0, d_stk}, 32'h0);

`ifdef DEBOUNCE_EN
    rst = 1'b0;
    tick();
    check_val("db_prime", {31'd0, d_out}, 32'h0);
    // 2-cycle glitch must be filtered out
    d_lvl = 1'b1;
    tick(); tick();
    d_lvl = 1'b0;
    for (int j = 0; j < 8; j++) begin
      tick();
      check_val("db_glitch", {31'd0, d_out}, 32'h0);
    end
    // 6-cycle high: pulse 4 cycles after s first shows the change
    d_lvl = 1'b1;
    for (int j = 0; j < 10; j++) begin
      tick();
      check_val($sformatf("db_hold_%0d", j), {31'd0, d_out}, {31'd0, (j == 4)});
      if (j == 5) d_lvl = 1'b0;
    end
    check_val("db_stk", {31'd0, d_stk}, 32'h1);
`else
    rst = 1'b0;
    tick();
    check_val("prime_a_out", {28'd0, a_out}, 32'h0);
    tick();
    check_val("held_high_a_out", {28'd0, a_out}, 32'h0);
    check_val("held_high_a_stk", {28'd0, a_stk}, 32'h0);

    // Single rising edge on channel 0: one-cycle pulse
    a_lvl[0] = 1'b1;
    tick();
    check_val("rise0_out", {28'd0, a_out}, 32'h1);
    check_val("rise0_stk", {28'd0, a_stk}, 32'h1);
    check_val("rise0_any", {31'd0, a_any}, 32'h1);
    tick();
    check_val("rise0_end_out", {28'd0, a_out}, 32'h0);
    check_val("rise0_end_any", {31'd0, a_any}, 32'h0);

    // Channel 2 (held through reset) 1->0->1 gives exactly one pulse
    a_lvl[2] = 1'b0;
    tick();
    check_val("ch2_fall_out", {28'd0, a_out}, 32'h0);
    a_lvl[2] = 1'b1;
    tick();
    check_val("ch2_rise_out", {28'd0, a_out}, 32'h4);
    check_val("ch2_rise_stk", {28'd0, a_stk}, 32'h5);
    a_clr = 4'b0001;
    tick();
    a_clr = 4'b0000;
    check_val("clr0_stk", {28'd0, a_stk}, 32'h4);

    // Fresh start, per-channel modes {11,10,01,00}
    rst = 1'b1;
    a_lvl = 4'b0000;
    tick(); tick();
    rst = 1'b0;
    a_mode = 8'b11_10_01_00;
    tick();
    a_lvl = 4'b1111;
    a_clr = 4'b0010;
    tick();
    a_clr = 4'b0000;
    check_val("all_rise_out", {28'd0, a_out}, 32'hA);
    check_val("all_rise_any", {31'd0, a_any}, 32'h1);
    check_val("set_wins_stk", {28'd0, a_stk}, 32'hA);
    a_lvl = 4'b0000;
    tick();
    check_val("all_fall_out", {28'd0, a_out}, 32'hC);
    check_val("all_fall_stk", {28'd0, a_stk}, 32'hE);
    // Mode off suppresses hits but history keeps tracking
    a_mode = 8'h00;
    a_lvl  = 4'b1111;
    tick();
    check_val("off_out", {28'd0, a_out}, 32'h0);
    a_mode = 8'h55;
    tick();
    check_val("off_tracked_out", {28'd0, a_out}, 32'h0);

    // Retrigger on C: second rise 3 cycles after the first -> 8 cycles high
    c_lvl = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      check_val($sformatf("retrig_%0d", i), {31'd0, c_out}, {31'd0, (i < 8)});
      if (i == 0) c_lvl = 1'b0;
      if (i == 2) c_lvl = 1'b1;
      tick();
    end
    check_val("retrig_stk", {31'd0, c_stk}, 32'h1);

    // Reset mid-pulse: output drops and nothing follows after release
    c_lvl = 1'b0;
    tick();
    c_lvl = 1'b1;
    tick();
    check_val("midpulse_pre", {31'd0, c_out}, 32'h1);
    rst = 1'b1;
    tick();
    check_val("midpulse_rst_out", {31'd0, c_out}, 32'h0);
    check_val("midpulse_rst_stk", {31'd0, c_stk}, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("after_rst_out", {31'd0, c_out}, 32'h0);
    end

    // B: both-edge mode through a 2-stage synchroniser, edges 10 cycles apart
    for (int e = 0; e < 3; e++) begin
      b_lvl = (e != 1);
      for (int j = 0; j < 10; j++) begin
        tick();
        check_val($sformatf("sync_e%0d_c%0d", e, j), {31'd0, b_out}, {31'd0, (j == 2)});
      end
    end
    check_val("sync_stk", {31'd0, b_stk}, 32'h1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
